voting_tally_ctrl: RTL and testbench

Sequential front-end for the ballot-counting datapath. Arbitrates `NUM_VOTERS` requesters onto one shared tally port, one ballot per cycle, and enforces one vote per voter per election. Accumulates per-candidate counts, then scans them serially to produce the winner. It sits between the voter interfaces and the result/readout logic.

---
 rtl/voting_tally_ctrl_if.sv | 30 +++
 rtl/voting_tally_ctrl.sv | 158 +++++++++++++++
 tb/tb_voting_tally_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/voting_tally_ctrl_if.sv
// rtl/voting_tally_ctrl_if.sv - voter request/ballot bus and election result signals
interface voting_tally_ctrl_if #(
    parameter int NUM_VOTERS = 4,
    parameter int NUM_CAND   = 4,
    parameter int CNT_W      = 8
);
    localparam int IW = $clog2(NUM_CAND);

    logic                           start;
    logic                           close;
    logic [NUM_VOTERS-1:0]          req;
    logic [NUM_VOTERS*NUM_CAND-1:0] ballot;
    logic [NUM_VOTERS-1:0]          gnt;
    logic                           busy;
    logic                           done;
    logic [IW-1:0]                  winner;
    logic [CNT_W-1:0]               winner_cnt;
    logic                           tie;
    logic [CNT_W-1:0]               invalid_cnt;

    modport master (
        output start, close, req, ballot,
        input  gnt, busy, done, winner, winner_cnt, tie, invalid_cnt
    );

    modport slave (
        input  start, close, req, ballot,
        output gnt, busy, done, winner, winner_cnt, tie, invalid_cnt
    );
endinterface

// File: rtl/voting_tally_ctrl.sv
// rtl/voting_tally_ctrl.sv - round-robin ballot arbiter, per-candidate tally and serial winner scan
module voting_tally_ctrl #(
    parameter int NUM_VOTERS = 4,
    parameter int NUM_CAND   = 4,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    voting_tally_ctrl_if.slave    bus
);
    localparam int IW = $clog2(NUM_CAND);
    localparam int PW = $clog2(NUM_VOTERS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_COMPARE, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      tally_q [NUM_CAND];
    logic [CNT_W-1:0]      tally_d [NUM_CAND];
    logic [CNT_W-1:0]      invalid_q, invalid_d;
    logic [NUM_VOTERS-1:0] voted_q, voted_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [IW-1:0]         scan_q, scan_d;
    logic [IW-1:0]         winner_q, winner_d;
    logic [CNT_W-1:0]      wcnt_q, wcnt_d;
    logic                  tie_q, tie_d;

    logic [NUM_VOTERS-1:0] elig;
    logic [NUM_VOTERS-1:0] gnt;
    logic                  gnt_any;
    logic [PW-1:0]         gnt_idx;
    logic [NUM_CAND-1:0]   slice;
    logic [IW-1:0]         cand_idx;
    int                    ones;
    int                    idx;

    // Search starts at the pointer and wraps; the first eligible voter wins.
    always_comb begin
        elig    = bus.req & ~voted_q;
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        if (state_q == S_COLLECT && !bus.close) begin
            for (int k = 0; k < NUM_VOTERS; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= NUM_VOTERS) idx = idx - NUM_VOTERS;
                if (!gnt_any && elig[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = PW'(idx);
                end
            end
        end
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

    always_comb begin
        slice    = bus.ballot[gnt_idx*NUM_CAND +: NUM_CAND];
        ones     = 0;
        cand_idx = '0;
        for (int c = 0; c < NUM_CAND; c++) begin
            if (slice[c]) begin
                ones     = ones + 1;
                cand_idx = IW'(c);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        tally_d   = tally_q;
        invalid_d = invalid_q;
        voted_d   = voted_q;
        ptr_d     = ptr_q;
        scan_d    = scan_q;
        winner_d  = winner_q;
        wcnt_d    = wcnt_q;
        tie_d     = tie_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    for (int c = 0; c < NUM_CAND; c++) tally_d[c] = '0;
                    invalid_d = '0;
                    voted_d   = '0;
                    state_d   = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (bus.close) begin
                    state_d = S_COMPARE;
                    scan_d  = '0;
                end else if (gnt_any) begin
                    voted_d = voted_q | gnt;
                    ptr_d   = (gnt_idx == PW'(NUM_VOTERS - 1)) ? '0 : PW'(int'(gnt_idx) + 1);
                    if (ones == 1) begin
                        if (tally_q[cand_idx] != CNT_MAX)
                            tally_d[cand_idx] = tally_q[cand_idx] + CNT_W'(1);
                    end else if (invalid_q != CNT_MAX) begin
                        invalid_d = invalid_q + CNT_W'(1);
                    end
                    if (&voted_d) begin
                        state_d = S_COMPARE;
                        scan_d  = '0;
                    end
                end
            end
            S_COMPARE: begin
                // Strictly-greater replacement keeps the lowest index on ties.
                if (scan_q == '0) begin
                    winner_d = '0;
                    wcnt_d   = tally_q[0];
                    tie_d    = 1'b0;
                end else if (tally_q[scan_q] > wcnt_q) begin
                    winner_d = scan_q;
                    wcnt_d   = tally_q[scan_q];
                    tie_d    = 1'b0;
                end else if (tally_q[scan_q] == wcnt_q) begin
                    tie_d    = 1'b1;
                end
                if (scan_q == IW'(NUM_CAND - 1)) state_d = S_DONE;
                else                            scan_d  = scan_q + IW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            for (int c = 0; c < NUM_CAND; c++) tally_q[c] <= '0;
            invalid_q <= '0;
            voted_q   <= '0;
            ptr_q     <= '0;
            scan_q    <= '0;
            winner_q  <= '0;
            wcnt_q    <= '0;
            tie_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tally_q   <= tally_d;
            invalid_q <= invalid_d;
            voted_q   <= voted_d;
            ptr_q     <= ptr_d;
            scan_q    <= scan_d;
            winner_q  <= winner_d;
            wcnt_q    <= wcnt_d;
            tie_q     <= tie_d;
        end
    end

    assign bus.gnt         = gnt;
    assign bus.busy        = (state_q == S_COLLECT) || (state_q == S_COMPARE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.winner      = winner_q;
    assign bus.winner_cnt  = wcnt_q;
    assign bus.tie         = tie_q;
    assign bus.invalid_cnt = invalid_q;
endmodule

// File: tb/tb_voting_tally_ctrl.sv
// tb/tb_voting_tally_ctrl.sv - randomized scoreboard bench for voting_tally_ctrl
module tb_voting_tally_ctrl;
    localparam int NV = 4;
    localparam int NC = 4;
    localparam int CW = 8;
    localparam int IW = $clog2(NC);
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    voting_tally_ctrl_if #(.NUM_VOTERS(NV), .NUM_CAND(NC), .CNT_W(CW)) bus ();
    voting_tally_ctrl #(.NUM_VOTERS(NV), .NUM_CAND(NC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    voting_tally_ctrl_if #(.NUM_VOTERS(5), .NUM_CAND(4), .CNT_W(2)) bus2 ();
    voting_tally_ctrl #(.NUM_VOTERS(5), .NUM_CAND(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst2), .bus(bus2)
    );

    typedef struct {
        logic [NV-1:0] gnt;
        logic          busy;
        logic          done;
        logic          res_ok;
        logic [IW-1:0] winner;
        logic [CW-1:0] wcnt;
        logic          tie;
        logic [CW-1:0] inv;
    } exp_t;

    exp_t gq[$];
    int checks = 0;
    int errors = 0;
    int rises = 0;
    int elections = 0;
    logic done_prev = 1'b0;

    // Reference model: 0 idle, 1 collect, 2 compare, 3 done
    int      m_state;
    int      tal[NC];
    int      inv;
    bit [NV-1:0] voted;
    int      ptr;
    int      scan;
    int      m_win, m_cnt;
    bit      m_tie;

    task automatic model_reset();
        m_state = 0;
        for (int c = 0; c < NC; c++) tal[c] = 0;
        inv = 0; voted = '0; ptr = 0; scan = 0;
        m_win = 0; m_cnt = 0; m_tie = 1'b0;
    endtask

    task automatic model_clear();
        for (int c = 0; c < NC; c++) tal[c] = 0;
        inv = 0; voted = '0;
    endtask

    task automatic model_result();
        int best, n;
        best = 0;
        for (int c = 1; c < NC; c++) if (tal[c] > tal[best]) best = c;
        n = 0;
        for (int c = 0; c < NC; c++) if (tal[c] == tal[best]) n++;
        m_win = best; m_cnt = tal[best]; m_tie = (n > 1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit c,
                        input logic [NV-1:0] rq, input logic [NV*NC-1:0] bl);
        exp_t e;
        bit [NV-1:0] elig;
        logic [NC-1:0] sl;
        int g, k;
        rst = r; bus.start = s; bus.close = c; bus.req = rq; bus.ballot = bl;
        g = -1;
        elig = rq & ~voted;
        if (m_state == 1 && !c)
            for (int j = 0; j < NV; j++)
                if (g < 0 && elig[(ptr + j) % NV]) g = (ptr + j) % NV;
        e.gnt    = (g >= 0) ? NV'(1 << g) : '0;
        e.busy   = (m_state == 1 || m_state == 2);
        e.done   = (m_state == 3);
        e.res_ok = (m_state != 2);
        e.winner = m_win[IW-1:0];
        e.wcnt   = m_cnt[CW-1:0];
        e.tie    = m_tie;
        e.inv    = inv[CW-1:0];
        gq.push_back(e);
        if (r) model_reset();
        else case (m_state)
            0, 3: if (s) begin model_clear(); m_state = 1; end
            1: begin
                if (c) begin
                    m_state = 2; scan = 0;
                end else if (g >= 0) begin
                    voted[g] = 1'b1;
                    ptr = (g + 1) % NV;
                    sl = bl[g*NC +: NC];
                    if ($countones(sl) == 1) begin
                        k = 0;
                        for (int cc = 0; cc < NC; cc++) if (sl[cc]) k = cc;
                        if (tal[k] < MAXC) tal[k]++;
                    end else if (inv < MAXC) inv++;
                    if (&voted) begin m_state = 2; scan = 0; end
                end
            end
            2: begin
                scan++;
                if (scan == NC) begin m_state = 3; model_result(); elections++; end
            end
            default: m_state = 0;
        endcase
        @(posedge clk); #1;
    endtask

    function automatic logic [NC-1:0] rand_ballot();
        int r;
        r = $urandom % 8;
        if (r < 6)  return NC'(1 << ($urandom % NC));
        if (r == 6) return '0;
        return NC'($urandom);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (bus.done && !done_prev) rises++;
        done_prev = bus.done;
        if (gq.size() > 0) begin
            e = gq.pop_front();
            checks++;
            if (bus.gnt !== e.gnt || bus.busy !== e.busy || bus.done !== e.done ||
                (e.res_ok && (bus.winner !== e.winner || bus.winner_cnt !== e.wcnt ||
                              bus.tie !== e.tie || bus.invalid_cnt !== e.inv))) begin
                errors++;
                $display("FAIL cycle t=%0t: gnt=%b busy=%b done=%b win=%0d cnt=%0d tie=%b inv=%0d, required gnt=%b busy=%b done=%b win=%0d cnt=%0d tie=%b inv=%0d (results %s)",
                         $time, bus.gnt, bus.busy, bus.done, bus.winner, bus.winner_cnt, bus.tie,
                         bus.invalid_cnt, e.gnt, e.busy, e.done, e.winner, e.wcnt, e.tie, e.inv,
                         e.res_ok ? "checked" : "ignored");
            end
        end
    end

    initial begin
        logic [NV*NC-1:0] bl;
        logic [NV-1:0] rq;
        int cyc;
        rst = 1'b1; bus.start = 1'b0; bus.close = 1'b0; bus.req = '0; bus.ballot = '0;
        rst2 = 1'b1; bus2.start = 1'b0; bus2.close = 1'b0; bus2.req = '0; bus2.ballot = '0;
        model_reset();
        @(posedge clk); #1;
        step(1, 0, 0, '0, '0);

        // Basic vote: grants 0..3, candidate 2 wins with 2
        bl = {4'b1000, 4'b0100, 4'b0100, 4'b0001};
        step(0, 1, 0, '0, '0);
        repeat (4) step(0, 0, 0, 4'hF, bl);
        repeat (NC + 2) step(0, 0, 0, '0, '0);
        chk("basic_winner", 32'(bus.winner), 2);
        chk("basic_cnt", 32'(bus.winner_cnt), 2);
        chk("basic_tie", 32'(bus.tie), 0);

        // Tie with close colliding with voter 2's request
        step(0, 1, 0, '0, '0);
        step(0, 0, 0, 4'b0001, 16'h0002);
        step(0, 0, 0, 4'b0010, 16'h0080);
        step(0, 0, 1, 4'b0100, 16'h0100);
        repeat (NC + 2) step(0, 0, 0, '0, '0);
        chk("tie_winner", 32'(bus.winner), 1);
        chk("tie_flag", 32'(bus.tie), 1);

        for (int n = 0; n < 3000; n++) begin
            rq = NV'($urandom_range(0, (1 << NV) - 1));
            for (int v = 0; v < NV; v++) bl[v*NC +: NC] = rand_ballot();
            step(($urandom % 400) == 0, ($urandom % 8) == 0, ($urandom % 10) == 0, rq, bl);
        end

        // Reset in the middle of the scan, then restart
        step(1, 0, 0, '0, '0);
        step(0, 1, 0, '0, '0);
        step(0, 0, 0, 4'b0011, 16'h0044);
        step(0, 0, 0, 4'b0011, 16'h0044);
        step(0, 0, 1, '0, '0);
        step(0, 0, 0, '0, '0);
        step(1, 0, 0, '0, '0);
        step(0, 0, 0, '0, '0);
        step(0, 1, 0, '0, '0);
        step(0, 0, 0, '0, '0);
        rst = 1'b0; bus.start = 1'b0; bus.close = 1'b0; bus.req = '0;
        @(posedge clk); #1;
        chk("done_rises", 32'(rises), 32'(elections));

        // Saturation on the narrow instance
        rst2 = 1'b0; bus2.start = 1'b1;
        @(posedge clk); #1;
        bus2.start = 1'b0; bus2.req = 5'h1F; bus2.ballot = 20'h11111;
        cyc = 0;
        while (!bus2.done && cyc < 40) begin @(posedge clk); #1; cyc++; end
        chk("sat_done", 32'(bus2.done), 1);
        chk("sat_cnt", 32'(bus2.winner_cnt), 3);
        chk("sat_winner", 32'(bus2.winner), 0);
        chk("sat_tie", 32'(bus2.tie), 0);
        chk("sat_inv0", 32'(bus2.invalid_cnt), 0);
        bus2.ballot = '0; bus2.start = 1'b1;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        chk("sat_restart_done", 32'(bus2.done), 0);
        cyc = 0;
        while (!bus2.done && cyc < 40) begin @(posedge clk); #1; cyc++; end
        chk("sat_inv", 32'(bus2.invalid_cnt), 3);
        chk("sat_empty_cnt", 32'(bus2.winner_cnt), 0);
        chk("sat_empty_tie", 32'(bus2.tie), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
